// File: rtl/ext_state_pkg.sv
`default_nettype none
// ============================================================================
// Module : ext_state_pkg
// Brief  : Shared types and sizing helpers for the external state loader.
// Rev    : 1.0
// ============================================================================
package ext_state_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      APPLY   = 2'd2
   } state_t;

   function automatic int nbeats(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-beat restore still needs a 1-bit counter to keep ports legal.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ext_state_beat_assembler.sv
`default_nettype none
// ============================================================================
// Module : ext_state_beat_assembler
// Brief  : Staging buffer that gathers restore beats, least-significant first.
// Rev    : 1.0
// ============================================================================
module ext_state_beat_assembler
   import ext_state_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_accept,
   input  logic [CHUNK-1:0] i_data,
   output logic [WIDTH-1:0] o_staging,
   output logic             o_last
);

   localparam int NBEATS = nbeats(WIDTH, CHUNK);
   localparam int CW     = cnt_width(NBEATS);
   localparam logic [CW-1:0] c_LAST = CW'(NBEATS - 1);

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_stage;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt   <= '0;
         r_stage <= '0;
      end else if (i_accept) begin
         r_stage[r_cnt*CHUNK +: CHUNK] <= i_data;
         r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + CW'(1);
      end
   end

   assign o_staging = r_stage;
   assign o_last    = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ext_state_loader.sv
`default_nettype none
// ============================================================================
// Module : ext_state_loader
// Brief  : Serial shift register whose contents can be restored in CHUNK beats.
// Rev    : 1.0
// ============================================================================
module ext_state_loader
   import ext_state_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             i,
   output logic             o,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [CHUNK-1:0] load_data,
   input  logic             load_abort,
   output logic             load_done,
   output logic             busy
);

   generate
      if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK || WIDTH < 2) begin : g_bad_geometry
         $error("ext_state_loader: WIDTH must be a multiple of CHUNK and at least 2");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic             r_done;

   logic             w_abort;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_staging;

   // An abort wins over a beat presented in the same cycle; APPLY ignores abort.
   assign w_abort  = load_abort && (r_state != APPLY);
   assign w_accept = load_valid && load_ready && !load_abort;

   ext_state_beat_assembler #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) u_assembler (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_abort),
      .i_accept  (w_accept),
      .i_data    (load_data),
      .o_staging (w_staging),
      .o_last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == APPLY) begin
            r_data  <= w_staging;
            r_done  <= 1'b1;
            r_state <= IDLE;
         end else begin
            if (en) begin
               r_data <= {r_data[WIDTH-2:0], i};
            end
            if (w_abort) begin
               r_state <= IDLE;
            end else if (w_accept) begin
               r_state <= w_last ? APPLY : COLLECT;
            end
         end
      end
   end

   assign o          = r_data[WIDTH-1];
   assign load_ready = !rst && (r_state != APPLY);
   assign busy       = (r_state != IDLE);
   assign load_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ext_state_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_ext_state_loader
// Brief  : Directed bench with a restore scoreboard for ext_state_loader.
// Rev    : 1.0
// ============================================================================
module tb_ext_state_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       i;
   logic       load_valid;
   logic       load_abort;
   logic [7:0] load_data;
   wire        o;
   wire        load_ready;
   wire        load_done;
   wire        busy;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;

   ext_state_loader #(.WIDTH(32), .CHUNK(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .i          (i),
      .o          (o),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_abort (load_abort),
      .load_done  (load_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Every load_done pulse must match the oldest outstanding restore.
   always @(negedge clk) begin
      if (load_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("restore_data", dut.r_data, mon_e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Tasks start and end 1ns after a rising edge.
   task automatic send_beat(input logic [7:0] d, output int waited);
      logic rdy;
      waited     = 0;
      load_valid = 1'b1;
      load_data  = d;
      rdy        = 1'b0;
      for (int k = 0; k < 20 && !rdy; k++) begin
         @(negedge clk);
         rdy = load_ready;
         if (!rdy) begin
            waited++;
            @(posedge clk);
            #1;
         end
      end
      if (!rdy) chk("beat_timeout", 32'(waited), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic finish_restore(input logic [31:0] v);
      load_valid = 1'b0;
      @(negedge clk);
      chk("apply_ready", load_ready, 0);
      chk("apply_busy", busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_pulse", load_done, 1);
      chk("done_o", o, v[31]);
      @(posedge clk);
      #1;
   endtask

   task automatic restore(input logic [31:0] v);
      int w;
      exp_q.push_back(v);
      for (int b = 0; b < 4; b++) begin
         send_beat(v[b*8 +: 8], w);
         if (b == 0) begin
            #3;
            chk("busy_after_first", busy, 1);
         end
      end
      finish_restore(v);
   endtask

   task automatic shift(input logic b, input int n);
      en = 1'b1;
      i  = b;
      repeat (n) @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   task automatic check_data(input string name, input logic [31:0] v);
      @(negedge clk);
      chk(name, dut.r_data, v);
      chk({name, "_o"}, o, v[31]);
      chk({name, "_done"}, load_done, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      rst = 1'b1; en = 1'b0; i = 1'b0;
      load_valid = 1'b0; load_abort = 1'b0; load_data = '0;

      @(negedge clk);
      chk("rst_ready", load_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", load_done, 0);
      chk("rst_data", dut.r_data, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", load_ready, 1);
      chk("idle_busy", busy, 0);
      @(posedge clk);
      #1;

      // Basic restore, then serial shifting of the restored value
      restore(32'h11223344);
      check_data("restore_hold", 32'h11223344);
      shift(1'b1, 1);
      check_data("shift1", 32'h22446689);
      shift(1'b0, 2);
      check_data("shift3", 32'h89119A24);

      // Shifting while beats are being collected
      restore(32'h80000000);
      exp_q.push_back(32'hABCD3344);
      en = 1'b1; i = 1'b0;
      send_beat(8'h44, w);
      send_beat(8'h33, w);
      load_valid = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b0;
      check_data("collect_shift", 32'h00000000);
      send_beat(8'hCD, w);
      send_beat(8'hAB, w);
      finish_restore(32'hABCD3344);

      // Abort with a beat presented in the same cycle
      send_beat(8'h44, w);
      send_beat(8'h33, w);
      load_data  = 8'h99;
      load_abort = 1'b1;
      @(negedge clk);
      chk("abort_ready", load_ready, 1);
      @(posedge clk);
      #1;
      load_abort = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      @(posedge clk);
      #1;
      check_data("abort_data", 32'hABCD3344);

      // Continuous valid: the fifth beat stalls through APPLY only
      exp_q.push_back(32'h04030201);
      send_beat(8'h01, w);
      send_beat(8'h02, w);
      send_beat(8'h03, w);
      send_beat(8'h04, w);
      exp_q.push_back(32'h88776655);
      send_beat(8'h55, w);
      chk("stall_cycles", 32'(w), 32'd1);
      send_beat(8'h66, w);
      send_beat(8'h77, w);
      send_beat(8'h88, w);
      finish_restore(32'h88776655);

      // Reset in the middle of collection
      send_beat(8'h10, w);
      send_beat(8'h20, w);
      send_beat(8'h30, w);
      load_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", load_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      @(posedge clk);
      #1;
      check_data("midrst_data", 32'h0);
      restore(32'hCAFEF00D);

      // Reset landing on the APPLY cycle
      send_beat(8'h01, w);
      send_beat(8'h02, w);
      send_beat(8'h03, w);
      send_beat(8'h04, w);
      load_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("applyrst_busy", busy, 0);
      @(posedge clk);
      #1;
      check_data("applyrst_data", 32'h0);
      restore(32'hDEADBEEF);

      // Shift request held across APPLY is dropped
      exp_q.push_back(32'h12345678);
      send_beat(8'h78, w);
      send_beat(8'h56, w);
      send_beat(8'h34, w);
      send_beat(8'h12, w);
      load_valid = 1'b0;
      en = 1'b1; i = 1'b1;
      @(negedge clk);
      chk("conflict_ready", load_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("conflict_done", load_done, 1);
      @(posedge clk);
      #1;
      en = 1'b0;
      check_data("conflict_resume", 32'h2468ACF1);

      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
